// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: 4-way round-robin arbiter feeding a single UART transmitter.
// Define UART_ARB_GAP_EN to hold GAP_CYCLES idle cycles after every byte.
module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 8192,
   parameter int unsigned GAP_CYCLES     = 50000
) (
   input  logic        CLK_50,
   input  logic        RST,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_byte,
   output logic [3:0]  req_ack,
   output logic [3:0]  req_done,
   output logic [3:0]  req_err,
   output logic        tx_dv,
   output logic [7:0]  tx_byte,
   input  logic        tx_active,
   input  logic        tx_done,
   output logic [1:0]  grant_id,
   output logic        busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   if (TIMEOUT_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cfg
      $error("uart_tx_arbiter: cycle parameters must be >= 1");
   end

`ifdef UART_ARB_GAP_EN
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_e;
   localparam state_e AFTER_TX = GAP;
   logic [GW-1:0] gap_q, gap_d;
`else
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_e;
   localparam state_e AFTER_TX = IDLE;
`endif

   state_e      state_q, state_d;
   logic [1:0]  rr_q, rr_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [3:0]  ack_q, ack_d;
   logic [3:0]  done_q, done_d;
   logic [3:0]  err_q, err_d;
   logic        dv_q, dv_d;
   logic [7:0]  byte_q, byte_d;
   logic [1:0]  gid_q, gid_d;
   logic        busy_q, busy_d;

   logic        win_vld;
   logic [1:0]  win_idx;

   // Descending scan so the lowest offset from rr_q wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = rr_q;
      for (int k = 3; k >= 0; k--) begin
         if (req_valid[rr_q + 2'(k)]) begin
            win_vld = 1'b1;
            win_idx = rr_q + 2'(k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      tmo_d   = '0;
      ack_d   = '0;
      done_d  = '0;
      err_d   = '0;
      dv_d    = 1'b0;
      byte_d  = byte_q;
      gid_d   = gid_q;
`ifdef UART_ARB_GAP_EN
      gap_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld && !tx_active) begin
               state_d = LAUNCH;
               byte_d  = req_byte[{win_idx, 3'b000} +: 8];
               gid_d   = win_idx;
               rr_d    = win_idx + 2'd1;
               ack_d[win_idx] = 1'b1;
               dv_d    = 1'b1;
            end
         end
         LAUNCH: state_d = WAIT_DONE;
         WAIT_DONE: begin
            tmo_d = tmo_q + 1'b1;
            // A done in the final timeout cycle still counts as done.
            if (tx_done) begin
               done_d[gid_q] = 1'b1;
               state_d = AFTER_TX;
            end else if (tmo_q == TMO_LAST) begin
               err_d[gid_q] = 1'b1;
               state_d = AFTER_TX;
            end
         end
`ifdef UART_ARB_GAP_EN
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK_50) begin
      if (RST) begin
         state_q <= IDLE;
         rr_q    <= '0;
         tmo_q   <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         err_q   <= '0;
         dv_q    <= 1'b0;
         byte_q  <= 8'h00;
         gid_q   <= '0;
         busy_q  <= 1'b0;
`ifdef UART_ARB_GAP_EN
         gap_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         tmo_q   <= tmo_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dv_q    <= dv_d;
         byte_q  <= byte_d;
         gid_q   <= gid_d;
         busy_q  <= busy_d;
`ifdef UART_ARB_GAP_EN
         gap_q   <= gap_d;
`endif
      end
   end

   assign req_ack  = ack_q;
   assign req_done = done_q;
   assign req_err  = err_q;
   assign tx_dv    = dv_q;
   assign tx_byte  = byte_q;
   assign grant_id = gid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and random
// traffic against a timestamp-based reference model of the arbiter.
module tb_uart_tx_arbiter;

   localparam int T = 20;
   localparam int G = 16;
`ifdef UART_ARB_GAP_EN
   localparam int GE = G;
`else
   localparam int GE = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_byte = '0;
   logic [3:0]  req_ack, req_done, req_err;
   logic        tx_dv, busy;
   logic [7:0]  tx_byte;
   logic [1:0]  grant_id;
   logic        tx_active = 1'b0;
   logic        tx_done = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
      .CLK_50(clk), .RST(rst),
      .req_valid(req_valid), .req_byte(req_byte),
      .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
      .tx_dv(tx_dv), .tx_byte(tx_byte),
      .tx_active(tx_active), .tx_done(tx_done),
      .grant_id(grant_id), .busy(busy)
   );

   typedef struct packed {
      logic [3:0] ack;
      logic [3:0] done;
      logic [3:0] err;
      logic       dv;
      logic [7:0] tbyte;
      logic [1:0] gid;
      logic       busy;
   } out_t;

   typedef struct {
      logic        r;
      logic [3:0]  v;
      logic [31:0] b;
      logic        a;
      logic        d;
      out_t        exp;
   } vec_t;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   out_t got_o, exp_o;

   // reference model: grant time stamps and pending ownership
   logic m_inflight = 1'b0;
   int m_idle_from = 0;
   int m_wait_start = 0;
   int m_owner = 0;
   int m_rr = 0;
   logic [7:0] m_byte = '0;
   logic [1:0] m_gid = '0;

   // bench-side requester / transmitter behaviour and event log
   logic [3:0] persist = '0;
   logic rand_req = 1'b0;
   int tx_mode = 0;
   int tx_len = 0;
   int tx_left = 0;
   int grants[$];
   int gaps[$];
   int n_done = 0, n_err = 0;
   int ack_cyc = 0, done_cyc = 0, err_cyc = 0, err_idx = 0;
   logic have_done = 1'b0;

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
      end
   endtask

   task automatic model_step();
      out_t e;
      int w;
      e = '0;
      if (rst) begin
         m_inflight = 1'b0;
         m_rr = 0;
         m_byte = '0;
         m_gid = '0;
         m_idle_from = cyc + 1;
      end else if (!m_inflight) begin
         if (cyc >= m_idle_from && req_valid != 0 && !tx_active) begin
            w = -1;
            for (int j = 0; j < 4; j++)
               if (w < 0 && req_valid[(m_rr + j) % 4]) w = (m_rr + j) % 4;
            m_inflight = 1'b1;
            m_wait_start = cyc + 2;
            m_owner = w;
            m_rr = (w + 1) % 4;
            m_byte = req_byte[8*w +: 8];
            m_gid = 2'(w);
            e.ack[w] = 1'b1;
            e.dv = 1'b1;
         end
      end else if (cyc >= m_wait_start) begin
         if (tx_done) begin
            e.done[m_owner] = 1'b1;
            m_inflight = 1'b0;
            m_idle_from = cyc + 1 + GE;
         end else if (cyc == m_wait_start + T - 1) begin
            e.err[m_owner] = 1'b1;
            m_inflight = 1'b0;
            m_idle_from = cyc + 1 + GE;
         end
      end
      e.tbyte = m_byte;
      e.gid = m_gid;
      e.busy = m_inflight || (cyc + 1 < m_idle_from);
      exp_o = e;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      got_o = {req_ack, req_done, req_err, tx_dv, tx_byte, grant_id, busy};
      check("model", got_o, exp_o);
      for (int i = 0; i < 4; i++) begin
         if (req_ack[i]) begin
            grants.push_back(i);
            ack_cyc = cyc;
            if (persist[i]) req_byte[8*i +: 8] = 8'($urandom);
            else req_valid[i] = 1'b0;
         end
         if (req_done[i]) begin
            n_done++;
            done_cyc = cyc;
            have_done = 1'b1;
         end
         if (req_err[i]) begin
            n_err++;
            err_cyc = cyc;
            err_idx = i;
         end
      end
      if (tx_dv && have_done) begin
         gaps.push_back(cyc - done_cyc);
         have_done = 1'b0;
      end
      if (rand_req) begin
         for (int i = 0; i < 4; i++) begin
            if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
               req_valid[i] = 1'b1;
               req_byte[8*i +: 8] = 8'($urandom);
            end else if (req_valid[i] && $urandom_range(0, 63) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      if (tx_mode != 0) begin
         tx_done = 1'b0;
         if (tx_dv) begin
            tx_active = 1'b1;
            tx_left = (tx_len > 0) ? tx_len : $urandom_range(1, T + 4);
         end else if (tx_active && tx_mode == 1) begin
            tx_left--;
            if (tx_left <= 0) begin
               tx_active = 1'b0;
               tx_done = 1'b1;
            end
         end else if (!tx_active && rand_req && $urandom_range(0, 15) == 0) begin
            tx_done = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      grants.delete();
      gaps.delete();
      n_done = 0;
      n_err = 0;
      have_done = 1'b0;
   endtask

   task automatic wait_grants(input int n, input int budget, input string nm);
      int b = 0;
      while (grants.size() < n && b < budget) begin
         tick();
         b++;
      end
      if (grants.size() < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: %0d grants, need %0d", nm, grants.size(), n);
      end
   endtask

   task automatic wait_err(input int n, input int budget, input string nm);
      int b = 0;
      while (n_err < n && b < budget) begin
         tick();
         b++;
      end
      if (n_err < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: %0d errs, need %0d", nm, n_err, n);
      end
   endtask

   function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] b,
                               logic a, logic d, logic [3:0] ack,
                               logic [3:0] dn, logic dv, logic [7:0] tb,
                               logic bsy);
      vec_t x;
      x.r = r; x.v = v; x.b = b; x.a = a; x.d = d;
      x.exp = '0;
      x.exp.ack = ack;
      x.exp.done = dn;
      x.exp.dv = dv;
      x.exp.tbyte = tb;
      x.exp.busy = bsy;
      return x;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int a;
      logic gb;
      gb = (GE > 0);
      vecs[0] = mk(1, 4'h0, 32'h0,  0, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      vecs[1] = mk(0, 4'h1, 32'h46, 1, 0, 4'h0, 4'h0, 0, 8'h00, 0);
      vecs[2] = mk(0, 4'h1, 32'h46, 0, 0, 4'h1, 4'h0, 1, 8'h46, 1);
      vecs[3] = mk(0, 4'h0, 32'h46, 1, 0, 4'h0, 4'h0, 0, 8'h46, 1);
      vecs[4] = mk(0, 4'h0, 32'h46, 1, 0, 4'h0, 4'h0, 0, 8'h46, 1);
      vecs[5] = mk(0, 4'h0, 32'h46, 0, 1, 4'h0, 4'h1, 0, 8'h46, gb);
      vecs[6] = mk(0, 4'h0, 32'h46, 0, 0, 4'h0, 4'h0, 0, 8'h46, gb);

      for (int i = 0; i < 7; i++) begin
         rst = vecs[i].r;
         req_valid = vecs[i].v;
         req_byte = vecs[i].b;
         tx_active = vecs[i].a;
         tx_done = vecs[i].d;
         tick();
         check($sformatf("vec%0d", i), got_o, vecs[i].exp);
      end
      tx_done = 1'b0;

      // all four requesting from reset
      req_valid = 4'hF;
      req_byte = $urandom;
      persist = 4'hF;
      tx_mode = 1;
      tx_len = 3;
      do_reset();
      wait_grants(8, 3000, "contend");
      for (int i = 0; i < 8 && i < grants.size(); i++)
         check($sformatf("contend%0d", i), grants[i], i % 4);

      // fairness between requesters 1 and 3
      req_valid = 4'b1010;
      persist = 4'b1010;
      do_reset();
      wait_grants(6, 3000, "fair");
      for (int i = 0; i < 6 && i < grants.size(); i++)
         check($sformatf("fair%0d", i), grants[i], (i % 2 == 0) ? 1 : 3);

      // timeout with a hung transmitter
      persist = '0;
      req_valid = '0;
      tx_active = 1'b0;
      tx_mode = 2;
      do_reset();
      req_valid = 4'b0100;
      wait_grants(1, 50, "tmo_grant");
      a = ack_cyc;
      wait_err(1, T + 20, "tmo_err");
      check("tmo_lat", err_cyc - a, T + 1);
      check("tmo_idx", err_idx, 2);
      check("tmo_nodone", n_done, 0);

      // tx_done in the final timeout cycle: done wins
      tx_mode = 0;
      tx_active = 1'b0;
      req_valid = 4'b1000;
      wait_grants(2, 100, "tie_grant");
      if (grants.size() >= 2) check("tie_idx", grants[1], 3);
      a = ack_cyc;
      while (cyc < a + T) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("tie_done", done_cyc, a + T + 1);
      check("tie_noerr", n_err, 1);

      // reset while waiting for the transmitter
      tx_mode = 2;
      do_reset();
      req_valid = 4'b0100;
      wait_grants(1, 50, "rstw_grant");
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstw_outs", got_o, '0);
      tx_mode = 0;
      tx_active = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (T + 4) tick();
      check("rstw_nodone", n_done, 0);
      check("rstw_noerr", n_err, 0);
      grants.delete();
      req_valid = 4'hF;
      tx_mode = 1;
      tx_len = 2;
      wait_grants(1, 50, "rstw_next");
      if (grants.size() >= 1) check("rstw_rr", grants[0], 0);

      // back-to-back spacing between done and next launch
      req_valid = 4'b0001;
      persist = 4'b0001;
      do_reset();
      wait_grants(3, 500, "gap");
      for (int i = 0; i < 2 && i < gaps.size(); i++)
         check($sformatf("gap%0d", i), gaps[i], GE + 1);

      // random traffic, random transmitter timing, spurious tx_done
      persist = '0;
      req_valid = '0;
      tx_len = 0;
      do_reset();
      rand_req = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8192: maximum WAIT_DONE cycles before abort (one byte takes 10 x 444 = 4440 cycles).
REQ-002 SHALL have parameter GAP_CYCLES, default 50000: idle cycles inserted after each byte when gap is enabled.
REQ-003 SHALL have port CLK_50  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  4  per-requester byte pending, held until acked.
REQ-006 SHALL have port req_byte  input  32  byte i in bits [8i+7:8i].
REQ-007 SHALL have port req_ack  output  4  one-cycle pulse: byte i accepted.
REQ-008 SHALL have port req_done  output  4  one-cycle pulse: byte i fully transmitted.
REQ-009 SHALL have port req_err  output  4  one-cycle pulse: byte i aborted by timeout.
REQ-010 SHALL have port tx_dv  output  1  transmitter start strobe.
REQ-011 SHALL have port tx_byte  output  8  byte to transmitter.
REQ-012 SHALL have port tx_active  input  1  transmitter busy.
REQ-013 SHALL have port tx_done  input  1  transmitter stop-bit-complete pulse.
REQ-014 SHALL have port grant_id  output  2  index of current or last granted requester.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, LAUNCH, WAIT_DONE, GAP; all outputs registered.
REQ-017 IDLE: if any req_valid bit set and tx_active low, SHALL select winner round-robin, searching from (rr_ptr) upward modulo 4, then go to LAUNCH; otherwise stay.
REQ-018 On IDLE->LAUNCH edge SHALL load tx_byte with winner's byte, set grant_id to winner, set rr_ptr to winner+1 mod 4.
REQ-019 In LAUNCH, tx_dv and req_ack[grant_id] SHALL be high for exactly that one cycle, then the block goes to WAIT_DONE.
REQ-020 Latency: request seen in IDLE at cycle N -> tx_dv and req_ack high at cycle N+1.
REQ-021 WAIT_DONE: on tx_done high SHALL pulse req_done[grant_id] next cycle and go to GAP (gap enabled) or IDLE.
REQ-022 WAIT_DONE: timeout counter starts at 0 on entry and increments each cycle; on reaching TIMEOUT_CYCLES-1 without tx_done SHALL pulse req_err[grant_id] and leave as for done.
REQ-023 tx_done and timeout in the same cycle: done wins, no err pulse.
REQ-024 tx_done outside WAIT_DONE SHALL be ignored.
REQ-025 A req_valid bit dropped before its ack SHALL not be granted; there is no ack without prior valid.
REQ-026 At most one req_ack, req_done or req_err bit SHALL be high in any cycle.
REQ-027 tx_byte and grant_id SHALL hold their values until the next grant.

Reset
REQ-028 When RST is high at a clock edge: state IDLE, rr_ptr 0, counters 0, tx_dv 0, tx_byte 8'h00, grant_id 0, req_ack/req_done/req_err 0, busy 0.
REQ-029 Reset mid-transfer SHALL abandon the byte silently: no done or err pulse. The transmitter is not reset by this block.

Configuration
REQ-030 Macro UART_ARB_GAP_EN defined: GAP state counts GAP_CYCLES cycles (busy high), then goes to IDLE. Undefined: GAP state and its counter are absent, WAIT_DONE goes directly to IDLE, and a new grant is possible the cycle after the done pulse.

Verification
REQ-031 Single request: req_valid=4'b0001, byte 8'h46; required: tx_dv and req_ack[0] one cycle later, tx_byte=8'h46, req_done[0] one cycle after tx_done.
REQ-032 Contention: all four valid from reset; required grant order 0,1,2,3, repeated, with each requester held until acked.
REQ-033 Fairness: requesters 1 and 3 continuously valid; required grants alternate 1,3,1,3.
REQ-034 Timeout: tx_done never asserted; required req_err[grant_id] after TIMEOUT_CYCLES cycles in WAIT_DONE, no req_done.
REQ-035 Reset in WAIT_DONE; required: all outputs 0 the next cycle, no done or err pulse, next grant to requester 0 when valid.
REQ-036 Gap: with UART_ARB_GAP_EN and GAP_CYCLES=16, back-to-back requests; required: tx_dv edges exactly 16 + 1 cycles after the previous req_done. Without the macro: a new grant the cycle after done.
